// File: rtl/vscpu_loader.sv
// -----------------------------------------------------------------------------
// vscpu_loader
//
// Purpose:
//   Boot-time program loader sitting between the VSCPU core and its blram.
//   The loader owns the single RAM port. While a load is running it holds
//   the core in reset. It also writes an incoming valid/ready word stream
//   into RAM, starting at address 0. After one extra reset cycle (FLUSH) it
//   releases the core and passes the core's RAM traffic straight through,
//   with no added latency.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-low reset
//   load_start  in   single-cycle pulse that starts a load (or a plain restart
//                    when load_len is zero)
//   load_len    in   number of words to load, sampled with load_start; values
//                    above DEPTH are clamped to DEPTH
//   s_valid     in   stream word valid
//   s_data      in   stream word
//   s_ready     out  loader accepts a stream word this cycle
//   cpu_rst     out  active-high reset to the core
//   cpu_wrEn    in   core write enable
//   cpu_addr    in   core RAM address
//   cpu_data    in   core write data
//   ram_we      out  blram write enable
//   ram_addr    out  blram address
//   ram_din     out  blram write data
//   busy        out  high while loading or flushing
//   done        out  high while the core is running
//   load_sum    out  modulo-2^DATA_W sum of the words written by the last load
// -----------------------------------------------------------------------------
module vscpu_loader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              cpu_rst,
    input  logic              cpu_wrEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] load_sum
);

    // DEPTH needs ADDR_W+1 bits so that a full-memory load can be counted
    // without the counter wrapping.
    localparam logic [ADDR_W:0]   DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     r_len;
    logic [DATA_W-1:0]   r_sum;

    logic                w_len_nz;
    logic [ADDR_W:0]     w_len_clamp;
    logic                w_start_load;
    logic                w_wr;
    logic                w_last;
    logic                w_pass;

    assign w_len_nz     = (load_len != CNT_ZERO);
    assign w_len_clamp  = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    assign w_start_load = load_start & w_len_nz;
    // A stream word is written in the same cycle it is accepted.
    assign w_wr         = (r_state == ST_LOAD) & s_valid;
    assign w_last       = w_wr & (r_cnt == (r_len - CNT_ONE));
    // A load request in RUN abandons the core's in-flight access that cycle.
    assign w_pass       = (r_state == ST_RUN) & ~w_start_load;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_state_nxt = w_len_nz ? ST_LOAD : ST_FLUSH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (load_start) begin
                    w_state_nxt = w_len_nz ? ST_LOAD : ST_FLUSH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word counter, latched length and running checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= CNT_ZERO;
            r_len <= CNT_ZERO;
            r_sum <= DATA_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_load) begin
                        r_len <= w_len_clamp;
                        r_cnt <= CNT_ZERO;
                        r_sum <= DATA_ZERO;
                    end else if (load_start) begin
                        // Zero-length start from IDLE reports an empty image.
                        r_sum <= DATA_ZERO;
                    end else begin
                        r_sum <= r_sum;
                    end
                end
                ST_LOAD: begin
                    if (w_wr) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        r_sum <= r_sum + s_data;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_RUN: begin
                    // A zero-length restart keeps the previous checksum.
                    if (w_start_load) begin
                        r_len <= w_len_clamp;
                        r_cnt <= CNT_ZERO;
                        r_sum <= DATA_ZERO;
                    end else begin
                        r_len <= r_len;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Output and RAM-port muxing.
    always_comb begin
        s_ready  = 1'b0;
        cpu_rst  = 1'b1;
        ram_we   = 1'b0;
        ram_addr = ADDR_ZERO;
        ram_din  = DATA_ZERO;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cpu_rst = 1'b1;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_wr) begin
                    ram_we   = 1'b1;
                    ram_addr = r_cnt[ADDR_W-1:0];
                    ram_din  = s_data;
                end else begin
                    ram_we   = 1'b0;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                done = 1'b1;
                if (w_pass) begin
                    cpu_rst  = 1'b0;
                    ram_we   = cpu_wrEn;
                    ram_addr = cpu_addr;
                    ram_din  = cpu_data;
                end else begin
                    cpu_rst  = 1'b1;
                end
            end
            default: begin
                cpu_rst = 1'b1;
            end
        endcase
    end

    assign load_sum = r_sum;

endmodule
